// File: rtl/loop_ctrl_ser_tx.sv
`default_nettype none
// ============================================================================
// loop_ctrl_ser_tx : framed MSB-first serial transmitter with even parity
// Revision 1.0
// ============================================================================
module loop_ctrl_ser_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             csn,
  output logic             sclk,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int HW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [HW-1:0] H_LAST = HW'(DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_sh;
  logic             par, par_nxt;
  logic [HW-1:0]    hcnt, hcnt_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic             csn_nxt, sclk_nxt, sdo_nxt, done_nxt, ready_nxt;
  logic             half_end;

  // Power/substrate pins carry no logic function.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  assign shreg_sh = shreg << 1;
  assign half_end = (hcnt == H_LAST);

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state     <= IDLE;
      shreg     <= '0;
      par       <= 1'b0;
      hcnt      <= '0;
      bcnt      <= '0;
      csn       <= 1'b1;
      sclk      <= 1'b0;
      sdo       <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      par       <= par_nxt;
      hcnt      <= hcnt_nxt;
      bcnt      <= bcnt_nxt;
      csn       <= csn_nxt;
      sclk      <= sclk_nxt;
      sdo       <= sdo_nxt;
      done      <= done_nxt;
      din_ready <= ready_nxt;
      busy      <= ~ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    par_nxt   = par;
    hcnt_nxt  = hcnt;
    bcnt_nxt  = bcnt;
    csn_nxt   = csn;
    sclk_nxt  = sclk;
    sdo_nxt   = sdo;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (din_valid) begin
          state_nxt = SHIFT;
          shreg_nxt = din;
          par_nxt   = ^din;
          hcnt_nxt  = '0;
          bcnt_nxt  = '0;
          csn_nxt   = 1'b0;
          sclk_nxt  = 1'b0;
          sdo_nxt   = din[WIDTH-1];
        end
      end
      SHIFT: begin
        if (!half_end) begin
          hcnt_nxt = hcnt + 1'b1;
        end else begin
          hcnt_nxt = '0;
          sclk_nxt = ~sclk;
          // Data only advances on the falling sclk edge that closes a bit.
          if (sclk) begin
            if (bcnt == B_LAST) begin
              state_nxt = PARITY;
              bcnt_nxt  = '0;
              sdo_nxt   = par;
            end else begin
              bcnt_nxt  = bcnt + 1'b1;
              shreg_nxt = shreg_sh;
              sdo_nxt   = shreg_sh[WIDTH-1];
            end
          end
        end
      end
      PARITY: begin
        if (!half_end) begin
          hcnt_nxt = hcnt + 1'b1;
        end else begin
          hcnt_nxt = '0;
          sclk_nxt = ~sclk;
          if (sclk) begin
            state_nxt = HOLD;
            sclk_nxt  = 1'b0;
            sdo_nxt   = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!half_end) begin
          hcnt_nxt = hcnt + 1'b1;
        end else begin
          hcnt_nxt  = '0;
          state_nxt = IDLE;
          csn_nxt   = 1'b1;
          sclk_nxt  = 1'b0;
          sdo_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        csn_nxt   = 1'b1;
        sclk_nxt  = 1'b0;
        sdo_nxt   = 1'b0;
      end
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

endmodule
`default_nettype wire

// File: doc/loop_ctrl_ser_tx.md
LOOP_CTRL_SER_TX -- requirements
Module: loop_ctrl_ser_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of data bits per frame (legal range 1..64).
REQ-002 The block SHALL have parameter DIV, default 4, giving the sclk half-period in CELCLK cycles (legal range 1..255).
REQ-003 Port CELCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port CELRST, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port CELV, input, 1 bit: supply pin, pass-through only, no logic function.
REQ-006 Port CELG, input, 1 bit: ground pin, pass-through only, no logic function.
REQ-007 Port SUB, input, 1 bit: substrate pin, pass-through only, no logic function.
REQ-008 Port din, input, WIDTH bits: parallel status word to transmit.
REQ-009 Port din_valid, input, 1 bit: din is valid.
REQ-010 Port din_ready, output, 1 bit: block can accept a word.
REQ-011 Port csn, output, 1 bit: frame select, active-low.
REQ-012 Port sclk, output, 1 bit: serial clock; the far-end receiver samples sdo on its rising edge.
REQ-013 Port sdo, output, 1 bit: serial data, MSB first.
REQ-014 Port busy, output, 1 bit: frame in progress.
REQ-015 Port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SHIFT, PARITY and HOLD.
REQ-017 din_ready SHALL be 1 only in IDLE, and busy SHALL equal the inverse of din_ready.
REQ-018 When din_valid=1 and din_ready=1 on an edge, the block SHALL do all of the following on that same edge:
- capture din into the shift register;
- compute even parity (XOR of all din bits);
- enter SHIFT with csn=0, sclk=0, sdo=din[WIDTH-1].
REQ-019 Each bit period SHALL be 2*DIV cycles:
- sclk=0 for the first DIV cycles, then 1 for the next DIV cycles;
- sdo SHALL change only on the edge where sclk goes 1->0 (or on frame entry), so it is stable around each rising sclk.
REQ-020 SHIFT SHALL transmit WIDTH bits MSB first, then enter PARITY with sdo=parity bit for one full bit period.
REQ-021 HOLD SHALL last DIV cycles with csn=0, sclk=0 and sdo=0, then return to IDLE.
REQ-022 On the HOLD->IDLE edge, csn SHALL go to 1 and done SHALL pulse 1 for exactly one cycle.
REQ-023 csn SHALL be low for exactly 2*DIV*(WIDTH+1)+DIV cycles per frame.
REQ-024 The half-period counter SHALL be $clog2(DIV+1) bits and the bit counter $clog2(WIDTH+1) bits, with no wrap beyond terminal counts.
REQ-025 din and din_valid SHALL be ignored while busy=1, and the captured word SHALL NOT change mid-frame.
REQ-026 If din_valid=1 on the cycle done=1, the word SHALL be accepted on the next edge, giving at least one IDLE cycle with csn=1 between frames.
REQ-027 With DIV=1, sclk SHALL toggle every cycle and all rules above SHALL still hold.
REQ-028 In IDLE, outputs SHALL be csn=1, sclk=0, sdo=0, done=0.
REQ-029 All outputs SHALL be driven directly from registers, with no combinational path from din or din_valid.

Reset
REQ-030 While CELRST=1 at an edge, the block SHALL enter IDLE with csn=1, sclk=0, sdo=0, done=0, busy=0, din_ready=1, and all counters and the shift register cleared.
REQ-031 CELRST asserted mid-frame SHALL abort the frame on that edge, with no done pulse.
REQ-032 CELRST SHALL take priority over a simultaneous din_valid, and the word SHALL NOT be accepted.
REQ-033 After CELRST deasserts, din_ready SHALL already be 1, so a word may be accepted on the first edge after release.

Verification
REQ-034 The bench SHALL cover a basic frame: WIDTH=16, DIV=4, din=0xA5C3 pulsed valid 1 cycle -> bits on rising sclk 1010010111000011 then parity 0; csn low 140 cycles; one done pulse.
REQ-035 The bench SHALL cover parity-one: din=0x0007 -> parity bit 1; din=0x8001 -> parity bit 0.
REQ-036 The bench SHALL cover back-to-back: din_valid held high with 0x1234 then 0x5678 -> two frames, csn high exactly 1 cycle between them, din changes during frame 1 not transmitted.
REQ-037 The bench SHALL cover reset mid-frame: CELRST for 1 cycle at bit 7 -> next cycle csn=1, sclk=0, sdo=0, din_ready=1, no done; a new frame then transmits correctly.
REQ-038 The bench SHALL cover DIV=1, WIDTH=1: din=1 -> sclk 0,1,0,1 over 4 cycles, data 1, parity 1; csn low 5 cycles.
REQ-039 The bench SHALL cover a reset/valid collision: CELRST=1 and din_valid=1 on the same edge -> no frame starts; csn stays 1.
